led_status_driver: RTL
======================

// Module: led_status_driver
// PURPOSE
//  Parametrised driver for the board's active-low status LEDs; supersedes the fixed 10-bit inverter.
//  Per-channel modes: direct, pulse-stretch (short bus events stay visible), blink-while-set, forced off.
//  Also provides a lamp-test override, input synchronisers and registered, polarity-corrected outputs.
//  Sits between the core status/debug bits and the LED pins.
// PARAMETERS
//  N_LEDS       10          number of LED channels
//  CLK_HZ       50_000_000  i_clk frequency; must be a multiple of 1000
//  STRETCH_MS   50          pulse-stretch hold time in ms, >=1
//  BLINK_HZ     2           blink rate; 500 % BLINK_HZ == 0
//  SYNC_STAGES  2           flops per input synchroniser, >=1
//  ACTIVE_LOW   1           1: LED lit = pin 0; 0: lit = pin 1
// PORTS
//  i_clk         in   1         single system clock
//  i_reset       in   1         asynchronous, active-high reset
//  i_inputbits   in   N_LEDS    status bits, asynchronous to i_clk, 1 = event/active
//  i_mode        in   2*N_LEDS  per-channel mode; channel k uses [2k+1:2k]; quasi-static, not synchronised
//  i_lamp_test   in   1         1 = all LEDs lit; synchronised like i_inputbits
//  o_outputbits  out  N_LEDS    LED pins, registered, polarity per ACTIVE_LOW
// BEHAVIOUR
//  Reset: async. o_outputbits = all-off (all 1s if ACTIVE_LOW, else all 0s). Sync flops, stretch counters,
//   ms prescaler, blink counter and blink phase all clear to 0. Reset mid-operation aborts everything at once.
//  Timebase: prescaler counts 0..CLK_HZ/1000-1; ms_tick is a 1-cycle pulse at terminal count.
//   The blink counter counts ms_ticks 0..(500/BLINK_HZ)-1. blink_phase toggles on wrap; first toggle -> 1 (on).
//  Synchroniser: s_in = i_inputbits delayed by SYNC_STAGES flops. i_lamp_test uses the same chain.
//  Stretch counter per channel, width $clog2(STRETCH_MS+1):
//   - s_in[k]==1: load STRETCH_MS. Load wins over a coincident ms_tick; retrigger reloads.
//   - else if ms_tick && cnt!=0: decrement. Saturates at 0 and never wraps.
//   - Runs in every mode; the result is only visible in stretch mode.
//  Lit logic (lit[k]):
//   - mode 00 DIRECT:  s_in[k]
//   - mode 01 STRETCH: s_in[k] | (cnt!=0)
//   - mode 10 BLINK:   s_in[k] & blink_phase
//   - mode 11 OFF:     0
//   - lamp test (synchronised) forces lit=1 on all channels, overriding mode 11.
//  Output: o_outputbits[k] <= ACTIVE_LOW ? ~lit[k] : lit[k], registered.
//   Latency from an i_inputbits edge to the pin is SYNC_STAGES+1 cycles.
//  Stretch visible duration after a 1-cycle s_in pulse: >(STRETCH_MS-1) ms and <=STRETCH_MS ms.
//   This depends on prescaler phase.
//  Mode change takes effect on the next output register update. A mode switch does not clear the counter.
//  Clearing a bit in BLINK mode turns the LED off after the normal latency, regardless of phase.
// STRUCTURE
//  Package led_pkg:
//   - typedef enum logic [1:0] led_mode_e {LED_DIRECT, LED_STRETCH, LED_BLINK, LED_OFF}
//   - function ms_div(CLK_HZ) = CLK_HZ/1000
//  Sub-module led_stretch_channel: synchroniser + stretch counter + mode mux for one channel.
//   Inputs: ms_tick, blink_phase, lamp_test. Output: lit. Instantiated N_LEDS times in a generate loop.
//  The top level holds the prescaler, blink counter/phase, lamp-test sync and output register/polarity.
// TESTING  (N_LEDS=4, CLK_HZ=10_000 -> 10 cycles/ms, STRETCH_MS=3, BLINK_HZ=250 -> toggle every 2 ms,
//           SYNC_STAGES=2, ACTIVE_LOW=1)
//  1 Reset: hold i_reset with i_inputbits=4'b1111, all DIRECT.
//    -> o_outputbits=4'b1111 throughout, and for 3 cycles after release; then 4'b0000.
//  2 Direct latency: all DIRECT, i_inputbits 0 -> 4'b0101 at cycle T.
//    -> o_outputbits=4'b1111 through T+2, 4'b1010 at T+3.
//  3 Stretch: ch0 STRETCH, 1-cycle pulse on bit0.
//    -> bit0 low for 21..30 cycles, then high.
//    A second pulse while low reloads the counter; measure the hold from the second pulse.
//  4 Blink: ch1 BLINK, bit1 held 1 from reset release.
//    -> bit1 first goes low at the first blink-phase toggle (cycle 20 after release + sync/register latency),
//    then toggles every 20 cycles. Drop bit1 -> high within 3 cycles.
//  5 Lamp test: modes {OFF,BLINK,STRETCH,DIRECT}, inputs 0, i_lamp_test=1.
//    -> 4'b0000 after 3 cycles. Release -> 4'b1111 after 3 cycles.
//  6 Reset mid-stretch: ch0 counter at 2, assert i_reset asynchronously.
//    -> bit0=1 in the same cycle. After release with inputs 0 -> bit0 stays 1 (counter cleared).

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the status LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    LED_DIRECT  = 2'b00,
    LED_STRETCH = 2'b01,
    LED_BLINK   = 2'b10,
    LED_OFF     = 2'b11
  } led_mode_e;

  function automatic int unsigned ms_div(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/led_stretch_channel.sv
// One LED channel: input synchroniser, pulse-stretch counter and mode mux.
module led_stretch_channel
  import led_pkg::*;
#(
  parameter int unsigned STRETCH_MS  = 50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_bit,
  input  logic [1:0] i_mode,
  input  logic       i_ms_tick,
  input  logic       i_blink_phase,
  input  logic       i_lamp_test,
  output logic       o_lit
);

  localparam int unsigned CW = $clog2(STRETCH_MS + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   w_s_in;
  led_mode_e              w_mode;

  assign w_s_in = r_sync[SYNC_STAGES-1];
  assign w_mode = led_mode_e'(i_mode);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_bit;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // A live input reloads even on a tick; the count saturates at zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_s_in) begin
      r_cnt <= CW'(STRETCH_MS);
    end else if (i_ms_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_comb begin
    o_lit = 1'b0;
    unique case (w_mode)
      LED_DIRECT:  o_lit = w_s_in;
      LED_STRETCH: o_lit = w_s_in | (r_cnt != '0);
      LED_BLINK:   o_lit = w_s_in & i_blink_phase;
      LED_OFF:     o_lit = 1'b0;
    endcase
    if (i_lamp_test) o_lit = 1'b1;
  end

endmodule

// File: rtl/led_status_driver.sv
// Status LED driver: shared ms/blink timebase, per-channel lit logic and
// registered, polarity-corrected pin outputs.
module led_status_driver
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS      = 10,
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned STRETCH_MS  = 50,
  parameter int unsigned BLINK_HZ    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [N_LEDS-1:0]     i_inputbits,
  input  logic [2*N_LEDS-1:0]   i_mode,
  input  logic                  i_lamp_test,
  output logic [N_LEDS-1:0]     o_outputbits
);

  localparam int unsigned MS_DIV   = ms_div(CLK_HZ);
  localparam int unsigned PW       = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int unsigned BLINK_MS = 500 / BLINK_HZ;
  localparam int unsigned BW       = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic        OFF_LVL  = (ACTIVE_LOW != 0);

  logic [PW-1:0]          r_presc;
  logic [BW-1:0]          r_blink_cnt;
  logic                   r_blink_phase;
  logic [SYNC_STAGES-1:0] r_lamp_sync;
  logic [N_LEDS-1:0]      r_out;
  logic                   w_ms_tick;
  logic                   w_lamp_test;
  logic [N_LEDS-1:0]      w_lit;

  assign w_ms_tick   = (r_presc == PW'(MS_DIV - 1));
  assign w_lamp_test = r_lamp_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
    end else if (w_ms_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Phase starts off, so the first toggle lights blinking channels.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_ms_tick) begin
      if (r_blink_cnt == BW'(BLINK_MS - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lamp_sync <= '0;
    end else begin
      r_lamp_sync[0] <= i_lamp_test;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_lamp_sync[i] <= r_lamp_sync[i-1];
      end
    end
  end

  for (genvar k = 0; k < N_LEDS; k++) begin : g_ch
    led_stretch_channel #(
      .STRETCH_MS  (STRETCH_MS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_bit         (i_inputbits[k]),
      .i_mode        (i_mode[2*k+1:2*k]),
      .i_ms_tick     (w_ms_tick),
      .i_blink_phase (r_blink_phase),
      .i_lamp_test   (w_lamp_test),
      .o_lit         (w_lit[k])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_out <= {N_LEDS{OFF_LVL}};
    end else begin
      r_out <= w_lit ^ {N_LEDS{OFF_LVL}};
    end
  end

  assign o_outputbits = r_out;

endmodule
